// File: rtl/mlopacc_batch.sv
// mlopacc_batch: two-stage batch accumulator.
// Stage 1 captures one operand per accepted handshake. Stage 2 adds the captured
// operand into the result register. After the last operand of a batch has been
// added, the result is held with a_vld until a_ack or clr.
// Optional feature: define MLOPACC_BATCH_SAT_EN to make the stage-2 add saturate
// at 2^AW-1. When it is undefined the add wraps modulo 2^AW. In both builds a
// carry out of the top bit sets the sticky ovf flag.
module mlopacc_batch #(
  parameter  int W    = 8,
  parameter  int AW   = 32,
  parameter  int MAXN = 255,
  localparam int CW   = $clog2(MAXN + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic [CW-1:0] n,
  input  logic [W-1:0]  x,
  input  logic          x_vld,
  output logic          x_rdy,
  output logic [AW-1:0] a,
  output logic          a_vld,
  input  logic          a_ack,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  xr_q, xr_d;
  logic          xr_v_q, xr_v_d;
  logic [AW-1:0] a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_q, n_d;
  logic          ovf_q, ovf_d;
  logic          a_vld_q, a_vld_d;

  logic          accept;
  logic [CW:0]   n_ext;
  logic [CW-1:0] neff;
  logic [CW-1:0] limit;
  logic [CW-1:0] cnt_inc;
  logic [AW:0]   sum;

  assign x_rdy  = (state_q == ACC);
  assign accept = x_vld & x_rdy;
  assign a      = a_q;
  assign a_vld  = a_vld_q;
  assign cnt    = cnt_q;
  assign ovf    = ovf_q;

  // Batch length clamp, and the limit used for this edge: a fresh clamp on the
  // first operand of a batch, the latched value for every later operand.
  always_comb begin
    n_ext   = {1'b0, n};
    neff    = n;
    if (n == '0) begin
      neff = CW'(1);
    end else if (n_ext > (CW + 1)'(MAXN)) begin
      neff = CW'(MAXN);
    end
    limit   = (cnt_q == '0) ? neff : n_q;
    cnt_inc = cnt_q + CW'(1);
    sum     = {1'b0, a_q} + {{(AW + 1 - W){1'b0}}, xr_q};
  end

  // Next-state logic: capture, accumulate, batch sequencing, ack and clear.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    xr_v_d  = 1'b0;
    a_d     = a_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    a_vld_d = a_vld_q;

    // Stage 2 runs whenever stage 1 holds an operand, whatever the state.
    if (xr_v_q) begin
`ifdef MLOPACC_BATCH_SAT_EN
      a_d = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
      a_d = sum[AW-1:0];
`endif
      ovf_d = ovf_q | sum[AW];
    end

    unique case (state_q)
      ACC: begin
        if (accept) begin
          xr_d   = x;
          xr_v_d = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_q == '0) begin
            n_d = neff;
          end
          if (cnt_inc == limit) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The final add lands on this same edge.
        state_d = DONE;
        a_vld_d = 1'b1;
      end
      DONE: begin
        if (a_ack) begin
          state_d = ACC;
          a_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          a_vld_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase

    // Clear overrides everything, including an in-flight stage-1 operand.
    if (clr) begin
      state_d = ACC;
      xr_v_d  = 1'b0;
      a_d     = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      a_vld_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ACC;
      xr_q    <= '0;
      xr_v_q  <= 1'b0;
      a_q     <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      a_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      xr_v_q  <= xr_v_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      a_vld_q <= a_vld_d;
    end
  end

endmodule
